fetch_aligner: RTL and testbench
================================

Name: fetch_aligner

Overview:
- Sits between the instruction memory/cache port and the decoder.
- Fetches word-aligned 32-bit words and realigns them into a stream of whole instructions, each with its own PC.
- Handles RVC 16-bit instructions and 32-bit instructions that straddle a word boundary.
- o_instr drives the decoder's opcode input directly; the decoder expands compressed opcodes itself.

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset.
- C_EN, 1, enables compressed handling. When 0, every instruction is 32-bit and flush PC bit 1 is ignored (treated as 0).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; asynchronous, active-high
- o_fetch_req  out  1  word fetch request
- o_fetch_addr  out  32  word address of the request, bits [1:0]=00
- i_fetch_ready  in  1  memory accepts the request this cycle
- i_fetch_data  in  32  returned word
- i_fetch_valid  in  1  i_fetch_data valid; returns are in order
- i_flush  in  1  redirect (branch/jump/trap)
- i_flush_pc  in  32  redirect target, halfword aligned
- o_instr  out  32  instruction to the decoder; bits [31:16]=0 when compressed
- o_pc  out  32  PC of o_instr
- o_compressed  out  1  o_instr is 16-bit (next PC = o_pc+2, otherwise o_pc+4)
- o_valid  out  1  o_instr/o_pc valid
- i_ready  in  1  decoder stage accepts the instruction

Behaviour:
- Reset state:
  - o_valid=0, o_fetch_req=0, o_pc=RESET_PC.
  - Queue count=0, outstanding=0, discard=0, fetch address=RESET_PC, skip_low=RESET_PC[1].
  - The first request asserts the first cycle after reset deasserts.
- Halfword queue:
  - Depth 4 halfwords; count is 0..4.
  - A push adds 2 halfwords, or only the upper halfword when skip_low=1; skip_low clears after that push.
  - A pop removes 1 halfword (compressed) or 2 halfwords (32-bit).
  - Push and pop in the same cycle are allowed. Count never exceeds 4, guaranteed by the request rule.
- Compressed test: the head halfword is compressed iff C_EN=1 and hw[1:0] != 2'b11.
- o_valid (combinational from registered state):
  - Asserted when (count>=1 and head compressed) or count>=2.
  - Forced to 0 while i_flush=1.
- o_instr:
  - Compressed: {16'h0, hw0}.
  - 32-bit: {hw1, hw0}.
- Handshake:
  - A transfer occurs on o_valid && i_ready; o_pc then advances by 2 or 4.
  - While i_ready=0, o_instr, o_pc and o_compressed hold stable.
- Request rule:
  - o_fetch_req=1 iff outstanding=0, discard=0, count<=2 and i_flush=0.
  - o_fetch_addr is registered and stays stable while o_fetch_req=1 and i_fetch_ready=0.
  - On acceptance: outstanding=1 and fetch address +4.
  - At most one request is outstanding.
- Return:
  - On i_fetch_valid with discard=0: push, outstanding=0. Data appears at o_valid no earlier than the cycle after i_fetch_valid.
  - On i_fetch_valid with discard=1: data dropped, outstanding=0, discard=0.
- Flush (highest priority in its cycle):
  - Queue emptied; any handshake or i_fetch_valid in that cycle is ignored.
  - o_pc=i_flush_pc; fetch address={i_flush_pc[31:2],2'b00}; skip_low=i_flush_pc[1]&C_EN.
  - If a request is outstanding and not returning in the flush cycle, discard=1.
  - Next request: the cycle after the flush, or the cycle after the discarded return.
- Wrap-around: the fetch address and PC wrap modulo 2^32 with no special handling.
- Reset mid-operation returns to the reset state immediately. A memory return arriving after reset deasserts with no request issued is ignored (outstanding=0).

Decomposition:
- Shared package:
  - RVC quadrant constant (2'b11 = uncompressed).
  - Queue depth constant (4) and count width (3).
  - Halfword and word widths.
- One sub-module, fetch_hword_queue: 4x16 shift/rotate queue with push1/push2/pop1/pop2 and clear. The aligner keeps the request/discard state machine and PC logic.

Test Plan:
- All 32-bit: words 0x00A00513@0x0, 0x00B00593@0x4 -> o_instr 0x00A00513 pc 0x0, then 0x00B00593 pc 0x4; o_compressed=0.
- Two compressed in one word: 0x45814501@0x0 -> 0x00004501 pc 0x0, then 0x00004581 pc 0x2; o_compressed=1 both.
- Straddle: 0x05134501@0x0, 0x458100A0@0x4 -> 0x00004501 pc 0x0; 0x00A00513 pc 0x2 (valid only after the second word arrives); 0x00004581 pc 0x6.
- Flush to 0x102 with a request outstanding -> stale return dropped; next o_fetch_addr=0x100; lower half skipped; first o_pc=0x102.
- Backpressure: i_ready=0 for 10 cycles -> o_instr/o_pc stable; no request while count>=3; count never exceeds 4; stream resumes in order.
- C_EN=0, word 0x00004501 -> issued as 32-bit o_instr 0x00004501, pc +4; i_rst pulsed mid-stream -> o_valid=0 immediately, next o_fetch_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_aligner_pkg.sv
// Shared widths, queue sizing and RVC decode helper for the fetch aligner.
package fetch_aligner_pkg;

   localparam int HW_W    = 16;
   localparam int WORD_W  = 32;
   localparam int Q_DEPTH = 4;
   localparam int CNT_W   = 3;

   // Low two bits of an uncompressed (32-bit) opcode
   localparam logic [1:0] RVC_UNCOMP = 2'b11;

   typedef logic [HW_W-1:0]  hword_t;
   typedef logic [CNT_W-1:0] qcnt_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DROP
   } fetch_st_e;

   function automatic logic is_rvc(input hword_t hw, input logic c_en);
      return c_en && (hw[1:0] != RVC_UNCOMP);
   endfunction

endpackage

// File: rtl/fetch_hword_queue.sv
// Four-entry halfword queue: pops rotate the array down by one or two entries,
// pushes append one or two halfwords behind whatever survives the pop.
module fetch_hword_queue
   import fetch_aligner_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              push,
   input  logic              push_hi_only,
   input  logic [WORD_W-1:0] push_data,
   input  logic              pop1,
   input  logic              pop2,
   output hword_t            hw0,
   output hword_t            hw1,
   output qcnt_t             count
);

   hword_t q     [Q_DEPTH];
   hword_t q_nxt [Q_DEPTH];
   qcnt_t  count_nxt;
   qcnt_t  pop_n;
   qcnt_t  base;

   // Next queue contents: pop first, then append at the new tail
   always_comb begin
      pop_n = pop2 ? qcnt_t'(2) : (pop1 ? qcnt_t'(1) : qcnt_t'(0));
      base  = count - pop_n;
      for (int i = 0; i < Q_DEPTH; i++) begin
         q_nxt[i] = q[i];
         if (pop2)
            q_nxt[i] = q[(i + 2) % Q_DEPTH];
         else if (pop1)
            q_nxt[i] = q[(i + 1) % Q_DEPTH];
         if (push) begin
            if (push_hi_only) begin
               if (qcnt_t'(i) == base)
                  q_nxt[i] = push_data[31:16];
            end else begin
               if (qcnt_t'(i) == base)
                  q_nxt[i] = push_data[15:0];
               if (qcnt_t'(i) == base + qcnt_t'(1))
                  q_nxt[i] = push_data[31:16];
            end
         end
      end
      count_nxt = base + (push ? (push_hi_only ? qcnt_t'(1) : qcnt_t'(2)) : qcnt_t'(0));
      if (clear)
         count_nxt = '0;
   end

   // Queue storage and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         for (int i = 0; i < Q_DEPTH; i++)
            q[i] <= '0;
      end else begin
         count <= count_nxt;
         for (int i = 0; i < Q_DEPTH; i++)
            q[i] <= q_nxt[i];
      end
   end

   assign hw0 = q[0];
   assign hw1 = q[1];

endmodule

// File: rtl/fetch_aligner.sv
// Realigns word fetches into whole RV32/RVC instructions with per-instruction PC.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no request outstanding; may request when queue has room
// ST_WAIT | one request outstanding, its data will be pushed
// ST_DROP | one request outstanding from before a flush, data is dropped
module fetch_aligner
   import fetch_aligner_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter bit          C_EN     = 1'b1
)
(
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_fetch_req,
   output logic [31:0] o_fetch_addr,
   input  logic        i_fetch_ready,
   input  logic [31:0] i_fetch_data,
   input  logic        i_fetch_valid,
   input  logic        i_flush,
   input  logic [31:0] i_flush_pc,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc,
   output logic        o_compressed,
   output logic        o_valid,
   input  logic        i_ready
);

   fetch_st_e   st, st_nxt;
   logic [31:0] fetch_addr;
   logic [31:0] pc;
   logic        skip_low;
   hword_t      hw0, hw1;
   qcnt_t       count;
   logic        head_rvc;
   logic        fire;
   logic        accept;
   logic        push;
   logic [31:0] flush_pc_eff;

   // Without compressed support a halfword-offset target is meaningless
   assign flush_pc_eff = {i_flush_pc[31:2], i_flush_pc[1] & C_EN, i_flush_pc[0]};

   assign head_rvc     = is_rvc(hw0, C_EN);
   assign o_valid      = !i_flush && ((count >= qcnt_t'(1) && head_rvc) || count >= qcnt_t'(2));
   assign fire         = o_valid && i_ready;
   assign o_fetch_req  = !i_rst && (st == ST_IDLE) && (count <= qcnt_t'(2)) && !i_flush;
   assign accept       = o_fetch_req && i_fetch_ready;
   assign push         = !i_flush && (st == ST_WAIT) && i_fetch_valid;
   assign o_instr      = head_rvc ? {16'h0000, hw0} : {hw1, hw0};
   assign o_compressed = head_rvc;
   assign o_pc         = pc;
   assign o_fetch_addr = fetch_addr;

   // Request/discard state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         st <= ST_IDLE;
      else
         st <= st_nxt;
   end

   // Next state: a flush turns an in-flight request into one to discard
   always_comb begin
      st_nxt = st;
      if (i_flush) begin
         st_nxt = (st != ST_IDLE && !i_fetch_valid) ? ST_DROP : ST_IDLE;
      end else begin
         case (st)
            ST_IDLE:          if (accept)        st_nxt = ST_WAIT;
            ST_WAIT, ST_DROP: if (i_fetch_valid) st_nxt = ST_IDLE;
            default:                             st_nxt = ST_IDLE;
         endcase
      end
   end

   // Fetch address, instruction PC and first-halfword skip
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         fetch_addr <= {RESET_PC[31:2], 2'b00};
         pc         <= RESET_PC;
         skip_low   <= RESET_PC[1];
      end else if (i_flush) begin
         fetch_addr <= {i_flush_pc[31:2], 2'b00};
         pc         <= flush_pc_eff;
         skip_low   <= flush_pc_eff[1];
      end else begin
         if (accept)
            fetch_addr <= fetch_addr + 32'd4;
         if (push)
            skip_low <= 1'b0;
         if (fire)
            pc <= pc + (head_rvc ? 32'd2 : 32'd4);
      end
   end

   fetch_hword_queue u_queue (
      .clk          (i_clk),
      .rst          (i_rst),
      .clear        (i_flush),
      .push         (push),
      .push_hi_only (skip_low),
      .push_data    (i_fetch_data),
      .pop1         (fire && head_rvc),
      .pop2         (fire && !head_rvc),
      .hw0          (hw0),
      .hw1          (hw1),
      .count        (count)
   );

endmodule

// File: tb/tb_fetch_aligner.sv
// Scoreboard bench for fetch_aligner: a compressed-enabled instance under
// directed and random traffic, and a C_EN=0 instance for 32-bit-only mode.
module tb_fetch_aligner;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        comp;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // compressed-enabled instance
   logic        i_rst = 1'b1, i_fetch_ready = 1'b0, i_fetch_valid = 1'b0;
   logic        i_flush = 1'b0, i_ready = 1'b0;
   logic [31:0] i_fetch_data = '0, i_flush_pc = '0;
   logic        o_fetch_req, o_compressed, o_valid;
   logic [31:0] o_fetch_addr, o_instr, o_pc;

   // C_EN=0 instance
   logic        n_rst = 1'b1, n_fetch_ready = 1'b0, n_fetch_valid = 1'b0;
   logic        n_flush = 1'b0, n_ready = 1'b0;
   logic [31:0] n_fetch_data = '0, n_flush_pc = '0;
   logic        n_fetch_req, n_comp, n_valid;
   logic [31:0] n_fetch_addr, n_instr, n_pc;

   fetch_aligner #(.RESET_PC(32'h0), .C_EN(1'b1)) dut (
      .i_clk(clk), .i_rst(i_rst), .o_fetch_req(o_fetch_req), .o_fetch_addr(o_fetch_addr),
      .i_fetch_ready(i_fetch_ready), .i_fetch_data(i_fetch_data), .i_fetch_valid(i_fetch_valid),
      .i_flush(i_flush), .i_flush_pc(i_flush_pc), .o_instr(o_instr), .o_pc(o_pc),
      .o_compressed(o_compressed), .o_valid(o_valid), .i_ready(i_ready));

   fetch_aligner #(.RESET_PC(32'h0), .C_EN(1'b0)) dut_nc (
      .i_clk(clk), .i_rst(n_rst), .o_fetch_req(n_fetch_req), .o_fetch_addr(n_fetch_addr),
      .i_fetch_ready(n_fetch_ready), .i_fetch_data(n_fetch_data), .i_fetch_valid(n_fetch_valid),
      .i_flush(n_flush), .i_flush_pc(n_flush_pc), .o_instr(n_instr), .o_pc(n_pc),
      .o_compressed(n_comp), .o_valid(n_valid), .i_ready(n_ready));

   logic [31:0] mem [256];
   exp_t exp_q[$];
   exp_t exp_b[$];
   int n_tests = 0, n_fail = 0;
   bit stall = 0, mem_rand = 1;
   int lat_lo = 0, lat_hi = 2, lat_b = 0;
   bit pend = 0, pend_b = 0;
   int cnt = 0, cnt_b = 0;
   logic [31:0] paddr, paddr_b;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Reference model: instruction stream read straight from memory at a PC
   function automatic logic [15:0] hw_at(input logic [31:0] a);
      logic [31:0] w;
      w = mem[a[9:2]];
      return a[1] ? w[31:16] : w[15:0];
   endfunction

   task automatic push_stream(input logic [31:0] start_pc, input int n);
      logic [31:0] p;
      logic [15:0] h;
      p = start_pc;
      for (int k = 0; k < n; k++) begin
         h = hw_at(p);
         if (h[1:0] != 2'b11) begin
            exp_q.push_back({{16'h0, h}, p, 1'b1});
            p = p + 32'd2;
         end else begin
            exp_q.push_back({{hw_at(p + 32'd2), h}, p, 1'b0});
            p = p + 32'd4;
         end
      end
   endtask

   task automatic push_a(input logic [31:0] ins, input logic [31:0] p, input logic c);
      exp_q.push_back({ins, p, c});
   endtask

   task automatic push_b(input logic [31:0] ins, input logic [31:0] p);
      exp_b.push_back({ins, p, 1'b0});
   endtask

   task automatic do_flush(input logic [31:0] p);
      i_flush = 1'b1;
      i_flush_pc = p;
      exp_q.delete();
      @(posedge clk); #1;
      i_flush = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int budget, input bit which_b);
      int k;
      k = 0;
      while ((which_b ? exp_b.size() : exp_q.size()) != 0 && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      chk(name, which_b ? exp_b.size() : exp_q.size(), 0);
   endtask

   // Decoder-side ready: only consume what the scoreboard expects
   initial forever begin
      @(posedge clk); #1;
      i_ready = (exp_q.size() != 0) && !stall && ($urandom_range(0, 3) != 0);
      n_ready = (exp_b.size() != 0);
   end

   // Memory model for the compressed instance
   initial forever begin
      @(posedge clk); #1;
      i_fetch_valid = 1'b0;
      if (pend) begin
         if (cnt == 0) begin
            i_fetch_valid = 1'b1;
            i_fetch_data  = mem[paddr[9:2]];
            pend = 0;
         end else cnt--;
      end
      i_fetch_ready = !pend && (!mem_rand || $urandom_range(0, 2) != 0);
      @(negedge clk);
      if (o_fetch_req && i_fetch_ready) begin
         pend = 1;
         paddr = o_fetch_addr;
         cnt = $urandom_range(lat_hi, lat_lo);
      end
   end

   // Memory model for the C_EN=0 instance
   initial forever begin
      @(posedge clk); #1;
      n_fetch_valid = 1'b0;
      if (pend_b) begin
         if (cnt_b == 0) begin
            n_fetch_valid = 1'b1;
            n_fetch_data  = mem[paddr_b[9:2]];
            pend_b = 0;
         end else cnt_b--;
      end
      n_fetch_ready = !pend_b;
      @(negedge clk);
      if (n_fetch_req && n_fetch_ready) begin
         pend_b = 1;
         paddr_b = n_fetch_addr;
         cnt_b = lat_b;
      end
   end

   // Monitor: compare transfers against the scoreboard, check held outputs
   initial begin
      exp_t e;
      bit hold_v, hold_r;
      logic [64:0] h_out;
      logic [31:0] h_addr;
      hold_v = 0;
      hold_r = 0;
      forever begin
         @(negedge clk);
         if (hold_v && !i_flush && !i_rst)
            chk("hold_out", {o_valid, o_instr, o_pc, o_compressed}, {1'b1, h_out});
         if (hold_r && !i_flush && !i_rst)
            chk("hold_addr", {o_fetch_req, o_fetch_addr}, {1'b1, h_addr});
         hold_v = o_valid && !i_ready && !i_flush && !i_rst;
         hold_r = o_fetch_req && !i_fetch_ready && !i_flush && !i_rst;
         h_out  = {o_instr, o_pc, o_compressed};
         h_addr = o_fetch_addr;
         if (!i_rst && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_instr", {o_instr, o_pc, o_compressed}, '1);
            end else begin
               e = exp_q.pop_front();
               chk("instr_pc_comp", {o_instr, o_pc, o_compressed}, e);
            end
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!n_rst && n_valid && n_ready) begin
            if (exp_b.size() == 0) begin
               chk("nc_unexpected", {n_instr, n_pc, n_comp}, '1);
            end else begin
               e = exp_b.pop_front();
               chk("nc_instr_pc_comp", {n_instr, n_pc, n_comp}, e);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int k;
      logic [31:0] rpc;
      for (int j = 0; j < 256; j++) mem[j] = $urandom();

      // all 32-bit, straight out of reset
      mem[0] = 32'h00A00513;
      mem[1] = 32'h00B00593;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", o_valid, 0);
      chk("rst_req", o_fetch_req, 0);
      chk("rst_pc", o_pc, 32'h0);
      i_rst = 1'b0;
      push_a(32'h00A00513, 32'h0, 1'b0);
      push_a(32'h00B00593, 32'h4, 1'b0);
      @(negedge clk);
      chk("first_req", {o_fetch_req, o_fetch_addr}, {1'b1, 32'h0});
      @(posedge clk); #1;
      wait_drain("drain_32bit", 100, 0);

      // two compressed in one word
      mem[0] = 32'h45814501;
      do_flush(32'h0);
      push_a(32'h00004501, 32'h0, 1'b1);
      push_a(32'h00004581, 32'h2, 1'b1);
      wait_drain("drain_two_rvc", 100, 0);

      // 32-bit instruction straddling a word boundary
      mem[0] = 32'h05134501;
      mem[1] = 32'h458100A0;
      do_flush(32'h0);
      push_a(32'h00004501, 32'h0, 1'b1);
      push_a(32'h00A00513, 32'h2, 1'b0);
      push_a(32'h00004581, 32'h6, 1'b1);
      wait_drain("drain_straddle", 100, 0);

      // flush with a request outstanding; stale data must be dropped
      mem[16] = 32'hDEAD0001;
      mem[64] = 32'h45814501;
      mem[65] = 32'h00B00593;
      mem_rand = 0;
      lat_lo = 6; lat_hi = 6;
      do_flush(32'h40);
      k = 0;
      while (!(pend && cnt >= 4) && k < 40) begin @(posedge clk); #1; k++; end
      chk("outstanding_before_flush", pend, 1);
      do_flush(32'h102);
      push_a(32'h00004581, 32'h102, 1'b1);
      push_a(32'h00B00593, 32'h104, 1'b0);
      @(negedge clk);
      chk("no_req_while_discard", o_fetch_req, 0);
      k = 0;
      while (!o_fetch_req && k < 30) begin @(negedge clk); k++; end
      chk("req_after_discard", {o_fetch_req, o_fetch_addr}, {1'b1, 32'h100});
      @(posedge clk); #1;
      wait_drain("drain_flush", 100, 0);

      // backpressure: hold outputs, queue fills, requests stop
      lat_lo = 0; lat_hi = 0;
      stall = 1;
      do_flush(32'h200);
      push_stream(32'h200, 20);
      repeat (12) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("bp_valid", o_valid, 1);
      chk("bp_no_req_full", o_fetch_req, 0);
      @(posedge clk); #1;
      stall = 0;
      wait_drain("drain_backpressure", 300, 0);

      // random traffic, random redirects, including address wrap
      mem_rand = 1;
      for (int it = 0; it < 40; it++) begin
         for (int j = 0; j < 256; j++) mem[j] = $urandom();
         lat_lo = 0;
         lat_hi = $urandom_range(0, 4);
         rpc = $urandom();
         rpc[0] = 1'b0;
         if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hE);
         do_flush(rpc);
         push_stream(rpc, 40);
         repeat ($urandom_range(5, 60)) begin @(posedge clk); #1; end
      end
      wait_drain("drain_random", 600, 0);

      // C_EN=0: compressed-looking opcodes issue as 32-bit
      mem[0] = 32'h00004501;
      mem[1] = 32'h00B00593;
      mem[2] = 32'h00004581;
      lat_b = 0;
      push_b(32'h00004501, 32'h0);
      push_b(32'h00B00593, 32'h4);
      push_b(32'h00004581, 32'h8);
      n_rst = 1'b0;
      wait_drain("nc_drain", 100, 1);

      // reset in the middle of a stream with a return still in flight
      lat_b = 3;
      for (int j = 3; j < 7; j++) push_b(mem[j], 32'(j * 4));
      k = 0;
      while (!pend_b && k < 40) begin @(posedge clk); #1; k++; end
      chk("nc_outstanding", pend_b, 1);
      n_rst = 1'b1;
      exp_b.delete();
      #1;
      chk("nc_rst_valid", n_valid, 0);
      chk("nc_rst_req", n_fetch_req, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_rst = 1'b0;
      push_b(32'h00004501, 32'h0);
      push_b(32'h00B00593, 32'h4);
      @(negedge clk);
      chk("nc_req_after_rst", {n_fetch_req, n_fetch_addr}, {1'b1, 32'h0});
      @(posedge clk); #1;
      wait_drain("nc_drain_after_rst", 100, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
